basic_compute_unit: RTL and testbench
=====================================

# basic_compute_unit

Two-operand, 4-bit arithmetic/logic unit with a serial capture handshake. Operands are loaded one at a time on a shared 4-bit data bus. After the second operand is captured, the selected operation is executed and a registered 5-bit result is presented with a one-cycle `valid` strobe. It sits behind a simple stimulus/control source that drives `capture`, `op` and `d_in` synchronously to `clock`.

## Interface
- No parameters; all widths are fixed.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low; sampled on the rising edge of `clock`.
- `d_in`  input  4  operand data, unsigned; sampled only when `capture`=1.
- `op`  input  2  operation select; sampled only on the capture that loads operand B.
- `capture`  input  1  load strobe; one operand is taken per clock in which it is high.
- `valid`  output  1  result strobe; high for exactly one cycle per completed operation.
- `result`  output  5  registered result; holds its value until the next operation completes.

## Operation
- Two-state FSM:
  - WAIT_A:
    - `capture`=1: A <= `d_in`; go to WAIT_B.
    - Otherwise: stay in WAIT_A.
  - WAIT_B:
    - `capture`=1: B = `d_in`, OP = `op`, compute; `result` <= f(A, B, OP); `valid` <= 1; go to WAIT_A.
    - Otherwise: stay in WAIT_B and keep A. There is no timeout.
- Operation encoding (A and B are unsigned 4-bit; all arithmetic is 5-bit):
  - `op`=00 ADD: {1'b0,A} + {1'b0,B}, range 0..30; bit 4 is the carry.
  - `op`=01 SUB: {1'b0,A} - {1'b0,B}, modulo 32 (two's complement); bit 4 set means A<B.
  - `op`=10 AND: {1'b0, A & B}.
  - `op`=11 XOR: {1'b0, A ^ B}.
- `op` is ignored when capturing operand A and in all cycles without `capture`.
- `d_in` is ignored whenever `capture`=0.
- Capturing B does not clear A internally, but the next capture always overwrites A.

## Timing
- Reset values (`rst_n`=0 at a rising edge): state=WAIT_A, A=0, `result`=5'd0, `valid`=0.
- Reset has priority over `capture`. Reset while in WAIT_B discards A, and no `valid` pulse is produced.
- Latency: `result` and `valid` update on the same rising edge that samples the second `capture`. Both are visible in the following cycle, which is 1 cycle of latency.
- `valid` deasserts on the next edge unless that edge completes another operation.
- Back-to-back capture: `capture` may be held high continuously.
  - Each edge alternates A load, B load/compute, A load, ...
  - Result: `valid` pulses every second cycle.
- A capture in the cycle where `valid`=1 is accepted as a new operand A.
- `result` is stable whenever `valid`=0 and is not cleared when `valid` falls.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `capture`=1 -> `valid`=0, `result`=0, and no operand is latched.
- ADD with carry: capture A=4'hF, then capture B=4'h1 with `op`=00 -> next cycle `valid`=1, `result`=5'd16; following cycle `valid`=0, `result` still 16.
- SUB borrow and ignored op: capture A=3 with `op`=10, wait 3 idle cycles, capture B=5 with `op`=01 -> `result`=5'b11110, `valid` pulses once.
- Logic ops: A=4'b1100, B=4'b1010 -> `op`=10 gives `result`=5'b01000; `op`=11 gives `result`=5'b00110.
- Streaming: `capture` held high for 6 cycles with `d_in`=1,2,3,4,5,6 and `op`=00 -> `valid` pulses 3 times with results 3, 7, 11.
- Mid-operation reset: capture A=9, assert `rst_n`=0 for 1 edge, then capture 2 and 3 with `op`=00 -> only one `valid` pulse, `result`=5.

Source files
------------

// File: rtl/basic_compute_unit.sv
// Two-operand 4-bit ALU. Operands arrive one per capture strobe on a shared bus;
// the B capture selects the operation and produces a registered result with a one-cycle valid.
module basic_compute_unit (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [3:0] d_in,
  input  logic [1:0] op,
  input  logic       capture,
  output logic       valid,
  output logic [4:0] result
);

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [4:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic [4:0] alu_out;

  // 5-bit arithmetic: bit 4 is carry for ADD and borrow (A<B) for SUB.
  always_comb begin
    alu_out = 5'd0;
    case (alu_op_t'(op))
      OP_ADD: alu_out = {1'b0, a_q} + {1'b0, d_in};
      OP_SUB: alu_out = {1'b0, a_q} - {1'b0, d_in};
      OP_AND: alu_out = {1'b0, a_q & d_in};
      OP_XOR: alu_out = {1'b0, a_q ^ d_in};
      default: alu_out = 5'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (capture) begin
          a_d     = d_in;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (capture) begin
          result_d = alu_out;
          valid_d  = 1'b1;
          state_d  = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= WAIT_A;
      a_q      <= 4'd0;
      result_q <= 5'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_basic_compute_unit.sv
// Directed bench for basic_compute_unit: hand-computed vectors checked one cycle
// after each driving edge.
module tb_basic_compute_unit;

  logic       clock;
  logic       rst_n;
  logic [3:0] d_in;
  logic [1:0] op;
  logic       capture;
  logic       valid;
  logic [4:0] result;

  int checks = 0;
  int errors = 0;

  basic_compute_unit dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .d_in   (d_in),
    .op     (op),
    .capture(capture),
    .valid  (valid),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One capture edge; capture drops afterwards unless the next call re-raises it
  // before the following edge.
  task automatic cap(input logic [3:0] d, input logic [1:0] o);
    capture = 1'b1;
    d_in    = d;
    op      = o;
    tick();
    capture = 1'b0;
  endtask

  task automatic idle();
    capture = 1'b0;
    d_in    = 4'hA;
    op      = 2'b11;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; capture = 1'b1; d_in = 4'hF; op = 2'b00;
    tick();
    tick();
    chk("rst_valid", {4'd0, valid}, 5'd0);
    chk("rst_result", result, 5'd0);
    rst_n = 1'b1;
    idle();
    chk("rst_idle_valid", {4'd0, valid}, 5'd0);

    // No operand latched during reset: first capture is A.
    cap(4'd1, 2'b00);
    chk("post_rst_a_valid", {4'd0, valid}, 5'd0);
    cap(4'd2, 2'b00);
    chk("post_rst_valid", {4'd0, valid}, 5'd1);
    chk("post_rst_result", result, 5'd3);

    // ADD with carry
    cap(4'hF, 2'b11);
    cap(4'h1, 2'b00);
    chk("add_valid", {4'd0, valid}, 5'd1);
    chk("add_result", result, 5'd16);
    idle();
    chk("add_valid_fall", {4'd0, valid}, 5'd0);
    chk("add_result_hold", result, 5'd16);

    // SUB borrow; op on the A capture is ignored
    cap(4'd3, 2'b10);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("sub_wait_valid", {4'd0, valid}, 5'd0);
      chk("sub_wait_result", result, 5'd16);
    end
    cap(4'd5, 2'b01);
    chk("sub_valid", {4'd0, valid}, 5'd1);
    chk("sub_result", result, 5'b11110);
    idle();
    chk("sub_valid_fall", {4'd0, valid}, 5'd0);

    // Logic ops
    cap(4'b1100, 2'b00);
    cap(4'b1010, 2'b10);
    chk("and_valid", {4'd0, valid}, 5'd1);
    chk("and_result", result, 5'b01000);
    cap(4'b1100, 2'b01);
    chk("xor_a_valid", {4'd0, valid}, 5'd0);
    cap(4'b1010, 2'b11);
    chk("xor_valid", {4'd0, valid}, 5'd1);
    chk("xor_result", result, 5'b00110);
    idle();

    // Streaming: capture held high, valid every second cycle
    cap(4'd1, 2'b00);
    chk("stream1_valid", {4'd0, valid}, 5'd0);
    chk("stream1_result", result, 5'b00110);
    cap(4'd2, 2'b00);
    chk("stream2_valid", {4'd0, valid}, 5'd1);
    chk("stream2_result", result, 5'd3);
    cap(4'd3, 2'b00);
    chk("stream3_valid", {4'd0, valid}, 5'd0);
    chk("stream3_result", result, 5'd3);
    cap(4'd4, 2'b00);
    chk("stream4_valid", {4'd0, valid}, 5'd1);
    chk("stream4_result", result, 5'd7);
    cap(4'd5, 2'b00);
    chk("stream5_valid", {4'd0, valid}, 5'd0);
    cap(4'd6, 2'b00);
    chk("stream6_valid", {4'd0, valid}, 5'd1);
    chk("stream6_result", result, 5'd11);
    idle();
    chk("stream_end_valid", {4'd0, valid}, 5'd0);

    // Mid-operation reset discards A and clears result
    cap(4'd9, 2'b00);
    rst_n = 1'b0;
    idle();
    chk("midrst_valid", {4'd0, valid}, 5'd0);
    chk("midrst_result", result, 5'd0);
    rst_n = 1'b1;
    cap(4'd2, 2'b00);
    chk("midrst_a_valid", {4'd0, valid}, 5'd0);
    cap(4'd3, 2'b00);
    chk("midrst_op_valid", {4'd0, valid}, 5'd1);
    chk("midrst_op_result", result, 5'd5);
    idle();
    chk("midrst_fall_valid", {4'd0, valid}, 5'd0);
    chk("midrst_hold_result", result, 5'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
